// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic port_t;

  localparam port_t P_CPU = 1'b0;
  localparam port_t P_EXT = 1'b1;

  // Latency counter width; covers MEM_LAT up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports (CPU and debug/DMA loader) plus the single memory port.
// slave: arbiter side. master: requesters and memory side.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that was not granted last time wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      lastGrant,
  output logic       valid,
  output port_t      pick
);

  // Combinational pick from the request pair and previous grant.
  always_comb begin
    valid = |req;
    pick  = P_CPU;
    if (req == 2'b11) begin
      pick = (lastGrant == P_CPU) ? P_EXT : P_CPU;
    end else if (req[1]) begin
      pick = P_EXT;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (port 0) and debug/DMA (port 1) accesses to the shared
// memory: IDLE picks and latches a request, ACCESS spans MEM_LAT cycles
// (strobe in the first), DONE pulses the granted port's ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            busy,
  output port_t           gnt
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  port_t            lastGrant;
  logic             weL;
  logic [AW-1:0]    addrL;
  logic [DW-1:0]    wdataL;
  logic [DW-1:0]    rdata0;
  logic [DW-1:0]    rdata1;

  logic             reqValid;
  port_t            pickPort;
  logic             grantNow;
  logic             lastAccess;
  logic             memEnC;
  logic             ack0;
  logic             ack1;

  rr_pick2 u_pick (
    .req       ({bus.m1_req, bus.m0_req}),
    .lastGrant (lastGrant),
    .valid     (reqValid),
    .pick      (pickPort)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and per-state strobes; mem_en marks the first ACCESS cycle
  // by the counter still holding its reload value.
  always_comb begin
    stateNext  = state;
    grantNow   = 1'b0;
    lastAccess = 1'b0;
    memEnC     = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          grantNow  = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        memEnC     = (cnt == LAT);
        lastAccess = (cnt == CNT_W'(1));
        if (lastAccess) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        ack0      = (gnt == P_CPU);
        ack1      = (gnt == P_EXT);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Grant bookkeeping, request latch, latency count and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= P_CPU;
      lastGrant <= P_EXT;
      cnt       <= '0;
      weL       <= 1'b0;
      addrL     <= '0;
      wdataL    <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else if (grantNow) begin
      gnt       <= pickPort;
      lastGrant <= pickPort;
      cnt       <= LAT;
      weL       <= (pickPort == P_EXT) ? bus.m1_we    : bus.m0_we;
      addrL     <= (pickPort == P_EXT) ? bus.m1_addr  : bus.m0_addr;
      wdataL    <= (pickPort == P_EXT) ? bus.m1_wdata : bus.m0_wdata;
    end else if (state == ACCESS) begin
      cnt <= cnt - CNT_W'(1);
      if (lastAccess && !weL) begin
        if (gnt == P_CPU) begin
          rdata0 <= bus.mem_rdata;
        end else begin
          rdata1 <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = memEnC;
  assign bus.mem_we    = memEnC & weL;
  assign bus.mem_addr  = addrL;
  assign bus.mem_wdata = wdataL;
  assign bus.m0_ack    = ack0;
  assign bus.m1_ack    = ack1;
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (MEM_LAT = 1, 2, 3) driven by independent random
// requesters and checked every cycle against a transaction-level model:
// a grant in idle cycle t yields mem_en at t+1 and ack at t+L+1, the
// arbiter is free again from t+L+2.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NI = 3;
  localparam int NCYC = 1200;
  localparam int TIE_START = 80;

  typedef enum {M_DIR2, M_DIR4, M_TIE, M_STREAM, M_RST5, M_RAND} mode_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0][1:0]         rq;
  logic [NI-1:0][1:0]         rqWe;
  logic [NI-1:0][1:0][AW-1:0] rqAddr;
  logic [NI-1:0][1:0][DW-1:0] rqWdata;
  logic [NI-1:0][DW-1:0]      memRdata;

  logic [NI-1:0]          ack0O, ack1O, memEnO, memWeO, busyO, gntO;
  logic [NI-1:0][AW-1:0]  memAddrO;
  logic [NI-1:0][DW-1:0]  memWdataO, rdata0O, rdata1O;

  for (genvar g = 0; g < NI; g++) begin : gInst
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    assign bus.m0_req    = rq[g][0];
    assign bus.m0_we     = rqWe[g][0];
    assign bus.m0_addr   = rqAddr[g][0];
    assign bus.m0_wdata  = rqWdata[g][0];
    assign bus.m1_req    = rq[g][1];
    assign bus.m1_we     = rqWe[g][1];
    assign bus.m1_addr   = rqAddr[g][1];
    assign bus.m1_wdata  = rqWdata[g][1];
    assign bus.mem_rdata = memRdata[g];
    assign ack0O[g]      = bus.m0_ack;
    assign ack1O[g]      = bus.m1_ack;
    assign rdata0O[g]    = bus.m0_rdata;
    assign rdata1O[g]    = bus.m1_rdata;
    assign memEnO[g]     = bus.mem_en;
    assign memWeO[g]     = bus.mem_we;
    assign memAddrO[g]   = bus.mem_addr;
    assign memWdataO[g]  = bus.mem_wdata;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(g + 1)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busyO[g]),
      .gnt  (gntO[g])
    );
  end

  // Reference model state, one slot per arbiter instance.
  bit          gv[NI];
  int          gc[NI];
  bit          owner[NI];
  bit          lastG[NI];
  bit          lWe[NI];
  logic [31:0] lAddr[NI];
  logic [31:0] lWdata[NI];
  logic [31:0] expRd[NI][2];
  bit          pend[NI][2];
  bit          ackLast[NI][2];

  int    vectors = 0;
  int    miscompares = 0;
  int    k = 0;
  mode_t mode = M_DIR2;
  bit    rst5Done = 1'b0;
  bit    rstHold = 1'b1;

  // Memory contents as a pure function of address.
  function automatic logic [31:0] memFn(logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic checkVal(string tag, int i, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d(lat=%0d) cycle %0d: got %h, expected %h",
               tag, i, i + 1, k, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      gv[i]     = 1'b0;
      gc[i]     = 0;
      owner[i]  = 1'b0;
      lastG[i]  = 1'b1;
      lWe[i]    = 1'b0;
      lAddr[i]  = '0;
      lWdata[i] = '0;
      for (int p = 0; p < 2; p++) begin
        expRd[i][p]   = '0;
        pend[i][p]    = 1'b0;
        ackLast[i][p] = 1'b0;
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < NI; i++) begin
      int L;
      bit act, en, ackCyc;
      L      = i + 1;
      act    = gv[i] && (k > gc[i]) && (k <= gc[i] + L + 1);
      en     = gv[i] && (k == gc[i] + 1);
      ackCyc = gv[i] && (k == gc[i] + L + 1);
      if (ackCyc && !lWe[i]) expRd[i][owner[i]] = memFn(lAddr[i]);
      ackLast[i][0] = ackCyc && (owner[i] == 1'b0);
      ackLast[i][1] = ackCyc && (owner[i] == 1'b1);
      checkVal("m0_ack",    i, 32'(ack0O[i]),  32'(ackLast[i][0]));
      checkVal("m1_ack",    i, 32'(ack1O[i]),  32'(ackLast[i][1]));
      checkVal("mem_en",    i, 32'(memEnO[i]), 32'(en));
      checkVal("mem_we",    i, 32'(memWeO[i]), 32'(en && lWe[i]));
      checkVal("busy",      i, 32'(busyO[i]),  32'(act));
      checkVal("gnt",       i, 32'(gntO[i]),   32'(owner[i]));
      checkVal("mem_addr",  i, memAddrO[i],    lAddr[i]);
      checkVal("mem_wdata", i, memWdataO[i],   lWdata[i]);
      checkVal("m0_rdata",  i, rdata0O[i],     expRd[i][0]);
      checkVal("m1_rdata",  i, rdata1O[i],     expRd[i][1]);
    end
  endtask

  task automatic grantStep();
    for (int i = 0; i < NI; i++) begin
      bit busyNow, p;
      busyNow = gv[i] && (k <= gc[i] + i + 2);
      if (!busyNow && (rq[i][0] || rq[i][1])) begin
        p = (rq[i][0] && rq[i][1]) ? !lastG[i] : rq[i][1];
        owner[i]  = p;
        lastG[i]  = p;
        lWe[i]    = rqWe[i][p];
        lAddr[i]  = rqAddr[i][p];
        lWdata[i] = rqWdata[i][p];
        gc[i]     = k;
        gv[i]     = 1'b1;
      end
    end
  endtask

  function automatic mode_t modeFor(int c);
    if (c < 40)        return M_DIR2;
    if (c < TIE_START) return M_DIR4;
    if (c < 150)       return M_TIE;
    if (c < 190)       return M_STREAM;
    if (c < 250)       return M_RST5;
    return M_RAND;
  endfunction

  function automatic bit wantRaise(int p);
    case (mode)
      M_DIR2:   return (p == 0) && ($urandom_range(0, 3) == 0);
      M_DIR4:   return (p == 1) && ($urandom_range(0, 3) == 0);
      M_TIE:    return 1'b1;
      M_STREAM: return (p == 0);
      M_RST5:   return rst5Done ? ((p == 1) && ($urandom_range(0, 2) == 0)) : (p == 0);
      default:  return $urandom_range(0, 2) == 0;
    endcase
  endfunction

  function automatic bit reissue(int p);
    case (mode)
      M_TIE:    return 1'b1;
      M_STREAM: return (p == 0);
      M_RAND:   return $urandom_range(0, 1) == 0;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic newReq(int i, int p);
    rq[i][p]      = 1'b1;
    pend[i][p]    = 1'b1;
    rqWdata[i][p] = $urandom;
    rqAddr[i][p]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    rqWe[i][p]    = 1'($urandom_range(0, 1));
    case (mode)
      M_DIR2: begin rqWe[i][p] = 1'b0; rqAddr[i][p] = 32'h10; end
      M_DIR4: begin rqWe[i][p] = 1'b1; rqAddr[i][p] = 32'h40; rqWdata[i][p] = 32'h12345678; end
      M_STREAM: rqWe[i][p] = 1'b0;
      M_RST5:   if (!rst5Done) rqWe[i][p] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        bit granted;
        granted = gv[i] && (owner[i] == 1'(p)) && (k > gc[i]) && (k <= gc[i] + i + 2);
        if (rstHold) begin
          rq[i][p] = 1'b0;
        end else if (ackLast[i][p]) begin
          pend[i][p] = 1'b0;
          if (reissue(p)) newReq(i, p);
          else rq[i][p] = 1'b0;
        end else if (!pend[i][p]) begin
          if (wantRaise(p)) newReq(i, p);
        end else if (granted && mode == M_RAND) begin
          int r;
          r = $urandom_range(0, 15);
          if (r == 0) begin
            rq[i][p] = 1'b0;
          end else if (r == 1) begin
            rqAddr[i][p]  = $urandom;
            rqWdata[i][p] = $urandom;
            rqWe[i][p]    = ~rqWe[i][p];
          end
        end
      end
      // Read data is valid only in the final access cycle.
      if (gv[i] && !lWe[i] && (k == gc[i] + i + 1)) memRdata[i] = memFn(lAddr[i]);
      else memRdata[i] = {16'hBAD0, 16'(k)};
    end
  endtask

  function automatic bit wantReset();
    if (k == TIE_START) return 1'b1;
    if (mode == M_RST5 && !rst5Done && gv[2] && owner[2] == 1'b0 && !lWe[2] &&
        k == gc[2] + 2) begin
      rst5Done = 1'b1;
      return 1'b1;
    end
    if (mode == M_RAND) return $urandom_range(0, 149) == 0;
    return 1'b0;
  endfunction

  initial begin
    rq = '0; rqWe = '0; rqAddr = '0; rqWdata = '0; memRdata = '0;
    modelReset();
    @(negedge clk);
    checkAll();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      k++;
      mode = modeFor(k);
      #1;
      drive();
      if (rstHold) begin
        #1;
        rst = 1'b0;
        rstHold = 1'b0;
      end
      @(negedge clk);
      checkAll();
      if (wantReset()) begin
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();
        rstHold = 1'b1;
      end else begin
        grantStep();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
